// File: rtl/if_fetch_if.sv
// if_fetch_if: fetch-stage bundle of control inputs, byte-memory port and IF/ID outputs
interface if_fetch_if #(
    parameter int ADDR_W = 32
);
    logic              rdy;
    logic [5:0]        stall;
    logic              branch_flag_i;
    logic [ADDR_W-1:0] branch_target_i;
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_busy_i;
    logic              mem_ack_i;
    logic [7:0]        mem_data_i;
    logic              get_inst_o;
    logic [ADDR_W-1:0] if_pc_o;
    logic [31:0]       if_inst_o;

    modport master (
        input  rdy, stall, branch_flag_i, branch_target_i, mem_busy_i, mem_ack_i, mem_data_i,
        output mem_req_o, mem_addr_o, get_inst_o, if_pc_o, if_inst_o
    );

    modport slave (
        output rdy, stall, branch_flag_i, branch_target_i, mem_busy_i, mem_ack_i, mem_data_i,
        input  mem_req_o, mem_addr_o, get_inst_o, if_pc_o, if_inst_o
    );
endinterface

// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage assembling 32-bit words from four little-endian byte reads
module if_fetch #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic        clk,
    input logic        rst,
    if_fetch_if.master bus
);
    typedef enum logic [1:0] {REQ, WAIT, VALID} phase_t;

    phase_t            r_phase;
    logic [1:0]        r_k;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_inst;
    logic              r_drop;
    logic [ADDR_W-1:0] r_if_pc;
    logic [31:0]       r_if_inst;
    logic              w_accept;
    logic              w_unused_stall;

    assign w_unused_stall  = ^bus.stall[5:1];
    assign bus.mem_req_o   = !rst && r_phase == REQ && !r_drop;
    assign bus.mem_addr_o  = rst ? '0 : r_pc + ADDR_W'(r_k);
    assign w_accept        = bus.mem_req_o && !bus.mem_busy_i;
    assign bus.get_inst_o  = !rst && r_phase == VALID && !bus.branch_flag_i;
    assign bus.if_pc_o     = r_if_pc;
    assign bus.if_inst_o   = r_if_inst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase   <= REQ;
            r_k       <= '0;
            r_pc      <= RESET_PC;
            r_inst    <= '0;
            r_drop    <= 1'b0;
            r_if_pc   <= '0;
            r_if_inst <= '0;
        end else if (bus.rdy) begin
            if (bus.branch_flag_i) begin
                r_pc    <= bus.branch_target_i;
                r_k     <= '0;
                r_phase <= REQ;
                // an ack arriving with the branch retires the old read; otherwise one is still in flight
                r_drop  <= !bus.mem_ack_i && (r_drop || r_phase == WAIT || w_accept);
            end else begin
                case (r_phase)
                    REQ: begin
                        if (r_drop) begin
                            if (bus.mem_ack_i)
                                r_drop <= 1'b0;
                        end else if (w_accept) begin
                            r_phase <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (bus.mem_ack_i) begin
                            r_inst[{r_k, 3'b000} +: 8] <= bus.mem_data_i;
                            if (r_k == 2'd3) begin
                                r_phase   <= VALID;
                                r_if_pc   <= r_pc;
                                r_if_inst <= {bus.mem_data_i, r_inst[23:0]};
                            end else begin
                                r_k     <= r_k + 2'd1;
                                r_phase <= REQ;
                            end
                        end
                    end
                    VALID: begin
                        if (!bus.stall[0]) begin
                            r_pc    <= r_pc + ADDR_W'(4);
                            r_k     <= '0;
                            r_phase <= REQ;
                        end
                    end
                    default: r_phase <= REQ;
                endcase
            end
        end
    end
endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage; sits directly upstream of the IF/ID pipeline register and drives its get_inst / if_pc / if_inst inputs.
- Assembles each 32-bit instruction from four little-endian byte reads through the shared byte-wide memory controller.
- Holds a completed instruction until IF/ID accepts it.
- Redirects on branch/jump, discarding any partially fetched instruction and any in-flight byte.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- ADDR_W, 32, width of PC and memory address.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rdy  in  1  global ready; when 0 every register in the block holds its value.
- stall  in  6  pipeline stall vector; only stall[0] is used (1 = IF/ID not accepting).
- branch_flag_i  in  1  redirect request from EX, one-cycle pulse.
- branch_target_i  in  ADDR_W  redirect PC.
- mem_req_o  out  1  byte-read request to memory controller.
- mem_addr_o  out  ADDR_W  byte address of request.
- mem_busy_i  in  1  controller serving another master; request not accepted this cycle.
- mem_ack_i  in  1  read data valid.
- mem_data_i  in  8  read byte.
- get_inst_o  out  1  if_inst_o/if_pc_o hold a complete instruction.
- if_pc_o  out  ADDR_W  PC of presented instruction.
- if_inst_o  out  32  presented instruction.

Behaviour:
- Memory protocol:
  - Request accepted in cycle N when mem_req_o=1 and mem_busy_i=0.
  - mem_ack_i with the byte arrives in a later cycle, at earliest N+1.
  - At most one request outstanding.
  - mem_req_o is held, with stable mem_addr_o, until accepted.
- State: phase in {REQ, WAIT, VALID}, byte index k in 0..3, pc register, 32-bit inst assembly register, drop flag.
- Reset (any cycle, including mid-fetch):
  - pc=RESET_PC, phase=REQ, k=0, drop=0, inst=0.
  - if_pc_o=0, if_inst_o=0, get_inst_o=0.
  - mem_req_o=0 and mem_addr_o=0 during the reset cycle.
  - The first request is issued in the cycle after rst deasserts.
- REQ:
  - mem_req_o=1, mem_addr_o=pc+k (wraps modulo 2^ADDR_W).
  - Accepted → WAIT.
  - Request is not issued while drop=1.
- WAIT:
  - mem_req_o=0.
  - On mem_ack_i: inst[8k+7:8k] <= mem_data_i.
  - If k<3: k++ and go to REQ.
  - If k=3: go to VALID, if_pc_o<=pc, if_inst_o<=assembled word.
  - Minimum latency: 8 cycles from first request to get_inst_o=1 with 1-cycle acks and no busy.
- VALID:
  - get_inst_o = 1 AND NOT branch_flag_i (combinational mask).
  - If stall[0]=0: pc<=pc+4, k=0, go to REQ next cycle.
  - Otherwise hold with outputs stable.
  - get_inst_o drops to 0 on leaving VALID; if_pc_o/if_inst_o retain their last values.
- Redirect (branch_flag_i=1, rdy=1; highest priority after rst):
  - pc<=branch_target_i, k=0, phase=REQ, get_inst_o=0 next cycle.
  - target bits[1:0] are used as-is; no alignment check.
  - Set drop=1 if a request is outstanding: phase WAIT without ack this cycle, or REQ accepted this cycle.
  - Ack in the same cycle as the branch is discarded and does not set drop.
- drop=1: the next mem_ack_i is discarded and drop clears; REQ for the new pc starts the cycle after.
- rdy=0 freezes pc, phase, k, inst, drop and all outputs.
  - mem_req_o stays as-is; the controller must not accept while rdy=0.
- stall[0] affects only the VALID→REQ transition.

Test Plan:
- Reset, memory bytes 0..3 = 13 05 10 00, 1-cycle acks, stall=0:
  - get_inst_o=1 at cycle 8 after reset release with if_pc_o=0, if_inst_o=32'h00100513.
  - Next request addresses are 4,5,6,7.
- stall[0]=1 held 5 cycles during VALID:
  - if_pc_o/if_inst_o stable, no mem_req_o.
  - On release, next request address = pc+4.
- mem_busy_i=1 for 3 cycles on byte 2:
  - mem_req_o and mem_addr_o=pc+2 held for 3 cycles.
  - Instruction still assembles correctly, 3 cycles later.
- branch_flag_i with target 32'h0000_0100 while in WAIT for byte 1:
  - Following stale ack (data 8'hFF) ignored.
  - Next request address 32'h100.
  - Assembled word contains no 8'hFF.
- branch_flag_i in VALID with stall[0]=0:
  - get_inst_o=0 in that cycle.
  - pc=target, next request address = target.
- rst asserted mid-fetch (k=2):
  - Next cycle outputs all zero, drop=0.
  - First request address = RESET_PC; the late ack is not expected.
